// File: rtl/pcpi_bf16_pkg.sv
// Shared definitions for the bf16 dot-product PCPI front-end.
//   state_e     : front-end sequencer states
//   DEF_*       : default custom-0 encoding of the dot-product instruction
//   operands_t  : the four bf16 operands handed to the datapath
//   insn_match  : instruction decode (valid + opcode/funct3/funct7 compare)
package pcpi_bf16_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ACCEPT,
      ST_WAIT_RESULT,
      ST_RESPOND,
      ST_DRAIN
   } state_e;

   localparam logic [6:0] DEF_OPCODE = 7'b0001011;
   localparam logic [2:0] DEF_FUNCT3 = 3'b000;
   localparam logic [6:0] DEF_FUNCT7 = 7'b0000001;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [15:0] d;
   } operands_t;

   // Register fields (rs1/rs2/rd) are don't-care, so the compare is done
   // under a mask covering only funct7, funct3 and the major opcode.
   function automatic logic insn_match(
      input logic        valid,
      input logic [31:0] insn,
      input logic [6:0]  opcode,
      input logic [2:0]  funct3,
      input logic [6:0]  funct7
   );
      logic [31:0] mask;
      logic [31:0] pattern;
      mask    = {7'h7f, 10'h000, 3'h7, 5'h00, 7'h7f};
      pattern = {funct7, 10'h000, funct3, 5'h00, opcode};
      return valid && ((insn & mask) == pattern);
   endfunction

endpackage

// File: rtl/pcpi_bf16_frontend.sv
// PCPI front-end for the bf16 dot-product co-processor.
// Decodes one custom instruction, splits rs1/rs2 into four bf16 operands,
// runs the STB/BUSY handshakes towards the datapath and returns the 16-bit
// a*b + c*d result zero-extended in rd. Also records issue-to-result latency.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2  CPU request
//   pcpi_wr/rd/wait/ready    CPU response (all registered)
//   op_a..op_d               datapath operands, stable for the whole op
//   op_input_STB / op_BUSY   datapath input handshake
//   op_result/op_output_STB  datapath result handshake; op_output_BUSY low
//   op_output_BUSY             means the front-end will take the result
//   last_latency             WAIT_ACCEPT+WAIT_RESULT cycles of the last op
module pcpi_bf16_frontend
   import pcpi_bf16_pkg::*;
#(
   parameter logic [6:0] OPCODE = DEF_OPCODE,
   parameter logic [2:0] FUNCT3 = DEF_FUNCT3,
   parameter logic [6:0] FUNCT7 = DEF_FUNCT7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic [15:0] op_c,
   output logic [15:0] op_d,
   output logic        op_input_STB,
   input  logic        op_BUSY,
   input  logic [15:0] op_result,
   input  logic        op_output_STB,
   output logic        op_output_BUSY,
   output logic [15:0] last_latency
);

   state_e      state;
   operands_t   ops;
   logic [15:0] cnt;
   logic        abort;
   logic        match;
   logic [15:0] cnt_inc;
   logic        aborting;

   assign match   = insn_match(pcpi_valid, pcpi_insn, OPCODE, FUNCT3, FUNCT7);
   assign cnt_inc = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
   // A request withdrawn in the very cycle the result arrives is treated as
   // aborted, so the CPU never sees a ready it no longer waits for.
   assign aborting = abort || !pcpi_valid;

   assign op_a = ops.a;
   assign op_b = ops.b;
   assign op_c = ops.c;
   assign op_d = ops.d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         ops            <= '0;
         cnt            <= '0;
         abort          <= 1'b0;
         pcpi_wr        <= 1'b0;
         pcpi_rd        <= '0;
         pcpi_wait      <= 1'b0;
         pcpi_ready     <= 1'b0;
         op_input_STB   <= 1'b0;
         op_output_BUSY <= 1'b1;
         last_latency   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               op_input_STB   <= 1'b0;
               op_output_BUSY <= 1'b1;
               // A busy datapath simply defers the issue; the CPU keeps the
               // request up and it is re-evaluated every cycle.
               if (match && !op_BUSY) begin
                  ops          <= '{a: pcpi_rs1[31:16], b: pcpi_rs1[15:0],
                                    c: pcpi_rs2[31:16], d: pcpi_rs2[15:0]};
                  pcpi_wait    <= 1'b1;
                  op_input_STB <= 1'b1;
                  cnt          <= '0;
                  abort        <= 1'b0;
                  state        <= ST_WAIT_ACCEPT;
               end
            end

            ST_WAIT_ACCEPT: begin
               cnt <= cnt_inc;
               if (!pcpi_valid) begin
                  abort     <= 1'b1;
                  pcpi_wait <= 1'b0;
               end
               if (op_BUSY) begin
                  op_input_STB   <= 1'b0;
                  op_output_BUSY <= 1'b0;
                  state          <= ST_WAIT_RESULT;
               end
            end

            ST_WAIT_RESULT: begin
               cnt <= cnt_inc;
               if (!pcpi_valid) begin
                  abort     <= 1'b1;
                  pcpi_wait <= 1'b0;
               end
               if (op_output_STB) begin
                  // The cycle that sees the result is counted as well.
                  last_latency <= cnt_inc;
                  if (!aborting) begin
                     pcpi_rd    <= {16'h0000, op_result};
                     pcpi_wr    <= 1'b1;
                     pcpi_ready <= 1'b1;
                     pcpi_wait  <= 1'b0;
                     state      <= ST_RESPOND;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end
            end

            ST_RESPOND: begin
               pcpi_ready <= 1'b0;
               pcpi_wr    <= 1'b0;
               state      <= ST_DRAIN;
            end

            ST_DRAIN: begin
               // Stay ready for the result until the producer has dropped
               // its strobe, so one result is never taken twice.
               if (!op_output_STB) begin
                  op_output_BUSY <= 1'b1;
                  state          <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_bf16_frontend.sv
module tb_pcpi_bf16_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_wr, pcpi_wait, pcpi_ready;
   logic [31:0] pcpi_rd;
   logic [15:0] op_a, op_b, op_c, op_d;
   logic        op_input_STB, op_BUSY, op_output_STB, op_output_BUSY;
   logic [15:0] op_result, last_latency;

   always #5 clk = ~clk;

   pcpi_bf16_frontend dut (
      .clk(clk), .rst(rst),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
      .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_input_STB(op_input_STB), .op_BUSY(op_BUSY),
      .op_result(op_result), .op_output_STB(op_output_STB),
      .op_output_BUSY(op_output_BUSY), .last_latency(last_latency)
   );

   localparam logic [31:0] INSN_OK = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference datapath: the basic test vector gives the true bf16 result
   // 1.0*2.0 + 3.0*4.0 = 14.0; other vectors use an operand-sensitive mix.
   function automatic logic [15:0] dp_ref(input logic [15:0] a, b, c, d);
      if ({a, b, c, d} == 64'h3f80_4000_4040_4080) return 16'h4160;
      return a ^ {b[7:0], b[15:8]} ^ (c + d);
   endfunction

   // ---------------- behavioural datapath ----------------
   logic        m_busy, ext_busy;
   int          m_st, m_cnt, wr_cycles;
   logic [15:0] m_a, m_b;

   assign op_BUSY = m_busy | ext_busy;

   // Takes a/b at accept but c/d only when producing the result, so any
   // operand movement during the op shows up as a wrong result.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_st <= 0; m_busy <= 1'b0; op_output_STB <= 1'b0; op_result <= '0;
         m_cnt <= 0; m_a <= '0; m_b <= '0;
      end else begin
         case (m_st)
            0: if (op_input_STB && !ext_busy) begin
               m_busy <= 1'b1; m_a <= op_a; m_b <= op_b;
               m_cnt <= wr_cycles - 1; m_st <= 1;
            end
            1: if (m_cnt == 0) begin
               op_output_STB <= 1'b1;
               op_result <= dp_ref(m_a, m_b, op_c, op_d);
               m_st <= 2;
            end else m_cnt <= m_cnt - 1;
            default: if (!op_output_BUSY) begin
               op_output_STB <= 1'b0; m_busy <= 1'b0; m_st <= 0;
            end
         endcase
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct { logic [31:0] rd; logic [15:0] lat; } exp_t;
   exp_t sb_q[$];
   int   ready_cnt = 0;
   logic prev_ready = 1'b0;
   logic [31:0] prev_rd = '0;

   always @(negedge clk) begin
      if (rst) begin
         if (pcpi_ready) begin
            ready_cnt <= ready_cnt + 1;
            if (sb_q.size() == 0) chk("unexp_ready", {31'h0, pcpi_ready}, 32'h0);
            else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("rd", pcpi_rd, e.rd);
               chk("wr_with_ready", {31'h0, pcpi_wr}, 32'h1);
               chk("wait_low_at_ready", {31'h0, pcpi_wait}, 32'h0);
               chk("last_latency", {16'h0, last_latency}, {16'h0, e.lat});
            end
         end
         if (prev_ready) begin
            chk("ready_1cyc", {31'h0, pcpi_ready}, 32'h0);
            chk("wr_1cyc", {31'h0, pcpi_wr}, 32'h0);
            chk("rd_hold", pcpi_rd, prev_rd);
         end
      end
      prev_ready <= rst && pcpi_ready;
      prev_rd    <= pcpi_rd;
   end

   // ---------------- CPU side ----------------
   task automatic run_op(input logic [31:0] rs1, input logic [31:0] rs2,
                         input int wr, input logic [15:0] exp_lat);
      exp_t e;
      int n;
      wr_cycles = wr;
      e.rd  = {16'h0, dp_ref(rs1[31:16], rs1[15:0], rs2[31:16], rs2[15:0])};
      e.lat = exp_lat;
      sb_q.push_back(e);
      pcpi_insn = INSN_OK; pcpi_rs1 = rs1; pcpi_rs2 = rs2; pcpi_valid = 1'b1;
      n = 0;
      while (!pcpi_wait && n < 50) begin @(negedge clk); n++; end
      chk("tmo_wait", {31'h0, pcpi_wait}, 32'h1);
      chk("op_ab", {op_a, op_b}, rs1);
      chk("op_cd", {op_c, op_d}, rs2);
      n = 0;
      while (!pcpi_ready && n < 200) begin @(negedge clk); n++; end
      chk("tmo_ready", {31'h0, pcpi_ready}, 32'h1);
      pcpi_valid = 1'b0;
      n = 0;
      while (!(op_output_BUSY && !op_output_STB && !pcpi_ready) && n < 50) begin
         @(negedge clk); n++;
      end
      repeat (2) @(negedge clk);
   endtask

   logic [31:0] bad_insn [3];
   logic        seen_wait, seen_ready, seen_stb;
   logic [31:0] rd_before;
   int          rc_before, n;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
      ext_busy = 1'b0; wr_cycles = 3;
      repeat (3) @(negedge clk);
      chk("rst_wr", {31'h0, pcpi_wr}, 32'h0);
      chk("rst_rd", pcpi_rd, 32'h0);
      chk("rst_wait", {31'h0, pcpi_wait}, 32'h0);
      chk("rst_ready", {31'h0, pcpi_ready}, 32'h0);
      chk("rst_ops", {op_a, op_b} | {op_c, op_d}, 32'h0);
      chk("rst_stb", {31'h0, op_input_STB}, 32'h0);
      chk("rst_obusy", {31'h0, op_output_BUSY}, 32'h1);
      chk("rst_lat", {16'h0, last_latency}, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // basic op
      run_op(32'h3f80_4000, 32'h4040_4080, 3, 16'd5);
      chk("basic_rd", pcpi_rd, 32'h0000_4160);

      // non-matching instructions must never be taken
      bad_insn[0] = {7'b0000000, INSN_OK[24:0]};
      bad_insn[1] = {INSN_OK[31:15], 3'b001, INSN_OK[11:0]};
      bad_insn[2] = {INSN_OK[31:7], 7'b0101011};
      foreach (bad_insn[k]) begin
         seen_wait = 1'b0; seen_ready = 1'b0; seen_stb = 1'b0;
         pcpi_insn = bad_insn[k]; pcpi_rs1 = 32'h1111_2222; pcpi_rs2 = 32'h3333_4444;
         pcpi_valid = 1'b1;
         repeat (20) begin
            @(negedge clk);
            seen_wait |= pcpi_wait; seen_ready |= pcpi_ready; seen_stb |= op_input_STB;
         end
         chk($sformatf("nm%0d_wait", k), {31'h0, seen_wait}, 32'h0);
         chk($sformatf("nm%0d_ready", k), {31'h0, seen_ready}, 32'h0);
         chk($sformatf("nm%0d_stb", k), {31'h0, seen_stb}, 32'h0);
         pcpi_valid = 1'b0;
         @(negedge clk);
      end

      // datapath busy at request time defers the issue
      ext_busy = 1'b1;
      seen_wait = 1'b0; seen_stb = 1'b0;
      pcpi_insn = INSN_OK; pcpi_rs1 = 32'h1234_abcd; pcpi_rs2 = 32'h0f0f_7070;
      pcpi_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         seen_wait |= pcpi_wait; seen_stb |= op_input_STB;
      end
      chk("busy_no_wait", {31'h0, seen_wait}, 32'h0);
      chk("busy_no_stb", {31'h0, seen_stb}, 32'h0);
      ext_busy = 1'b0;
      run_op(32'h1234_abcd, 32'h0f0f_7070, 4, 16'd6);

      // latency: accept takes 2 cycles, result in the 8th WAIT_RESULT cycle;
      // result has bit 15 set to expose any sign extension
      run_op(32'hc000_1234, 32'h0001_0002, 8, 16'd10);
      chk("zext_rd", pcpi_rd, 32'h0000_f411);

      // abort in WAIT_RESULT
      rd_before = pcpi_rd;
      wr_cycles = 6;
      pcpi_insn = INSN_OK; pcpi_rs1 = 32'h5555_0101; pcpi_rs2 = 32'h0202_0303;
      pcpi_valid = 1'b1;
      n = 0;
      while (!(pcpi_wait && !op_output_BUSY) && n < 50) begin @(negedge clk); n++; end
      chk("abort_in_wr", {31'h0, op_output_BUSY}, 32'h0);
      @(negedge clk);
      rc_before = ready_cnt;
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk("abort_wait", {31'h0, pcpi_wait}, 32'h0);
      seen_stb = 1'b0;
      n = 0;
      while (!(seen_stb && op_output_BUSY && !op_output_STB) && n < 100) begin
         @(negedge clk); n++;
         seen_stb |= op_output_STB;
      end
      chk("abort_drained_stb", {31'h0, seen_stb}, 32'h1);
      chk("abort_obusy", {31'h0, op_output_BUSY}, 32'h1);
      chk("abort_out_stb", {31'h0, op_output_STB}, 32'h0);
      chk("abort_no_ready", ready_cnt, rc_before);
      chk("abort_rd", pcpi_rd, rd_before);
      chk("abort_lat", {16'h0, last_latency}, 32'd8);
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of WAIT_RESULT
      wr_cycles = 10;
      pcpi_insn = INSN_OK; pcpi_rs1 = 32'h7777_8888; pcpi_rs2 = 32'h9999_aaaa;
      pcpi_valid = 1'b1;
      n = 0;
      while (!(pcpi_wait && !op_output_BUSY) && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_wr", {31'h0, pcpi_wr}, 32'h0);
      chk("arst_rd", pcpi_rd, 32'h0);
      chk("arst_wait", {31'h0, pcpi_wait}, 32'h0);
      chk("arst_ready", {31'h0, pcpi_ready}, 32'h0);
      chk("arst_ab", {op_a, op_b}, 32'h0);
      chk("arst_cd", {op_c, op_d}, 32'h0);
      chk("arst_stb", {31'h0, op_input_STB}, 32'h0);
      chk("arst_obusy", {31'h0, op_output_BUSY}, 32'h1);
      chk("arst_lat", {16'h0, last_latency}, 32'h0);
      pcpi_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(32'h4000_3f80, 32'h4080_4040, 2, 16'd4);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/pcpi_bf16_frontend.md
# pcpi_bf16_frontend

PCPI front-end for the bf16 dot-product co-processor. It sits between the picorv32 PCPI port and the `operation1` datapath. It decodes one custom instruction and splits rs1/rs2 into four bf16 operands. It then drives the datapath's STB/BUSY input and output handshakes, and returns the 16-bit `a*b + c*d` result to the CPU zero-extended in rd. It also records the issue-to-result latency of the last instruction.

## Interface
Parameters:
- OPCODE, 7'b0001011, custom-0 major opcode matched against insn[6:0]
- FUNCT3, 3'b000, matched against insn[14:12]
- FUNCT7, 7'b0000001, matched against insn[31:25]

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- pcpi_valid  in  1  CPU request valid
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  {a, b} bf16 pair
- pcpi_rs2  in  32  {c, d} bf16 pair
- pcpi_wr  out  1  write rd, pulses with pcpi_ready
- pcpi_rd  out  32  result {16'h0, result}
- pcpi_wait  out  1  instruction accepted, in progress
- pcpi_ready  out  1  one-cycle completion pulse
- op_a, op_b, op_c, op_d  out  16 each  datapath operands
- op_input_STB  out  1  datapath input strobe
- op_BUSY  in  1  datapath busy
- op_result  in  16  datapath result
- op_output_STB  in  1  datapath result strobe
- op_output_BUSY  out  1  consumer busy; low = ready to take result
- last_latency  out  16  cycles spent in WAIT_ACCEPT+WAIT_RESULT for the last completed or aborted op

## Operation
- match = pcpi_valid && opcode, funct3 and funct7 equal their parameters.
- State IDLE:
  - op_input_STB=0, op_output_BUSY=1.
  - On match && !op_BUSY: latch op_a=rs1[31:16], op_b=rs1[15:0], op_c=rs2[31:16], op_d=rs2[15:0]. Set pcpi_wait=1, op_input_STB=1, clear counter and abort flag. Go to WAIT_ACCEPT.
  - Match with op_BUSY=1: stay in IDLE, no outputs change.
- State WAIT_ACCEPT: hold STB and operands. On op_BUSY=1: STB=0, op_output_BUSY=0, go to WAIT_RESULT.
- State WAIT_RESULT:
  - Operands stay stable; the datapath reads c/d late.
  - On op_output_STB=1: capture op_result, and copy counter+1 to last_latency.
  - If not aborted: pcpi_rd={16'h0,op_result}, pcpi_wr=1, pcpi_ready=1, pcpi_wait=0. Go to RESPOND.
- State RESPOND: pcpi_ready=0, pcpi_wr=0; pcpi_rd holds. Go to DRAIN.
- State DRAIN: keep op_output_BUSY=0 until op_output_STB=0 is sampled. Then op_output_BUSY=1, go to IDLE.
- Counter: 16-bit, +1 per cycle in WAIT_ACCEPT and WAIT_RESULT, saturates at 16'hFFFF.
- Abort: pcpi_valid=0 sampled in WAIT_ACCEPT or WAIT_RESULT sets the abort flag and drops pcpi_wait.
  - The datapath transaction still completes and is drained.
  - At capture, pcpi_ready and pcpi_wr stay 0 and pcpi_rd is unchanged; last_latency still updates.
  - WAIT_RESULT goes straight to DRAIN.
- No arithmetic on data. The result is zero-extended, never sign-extended.

## Timing
- Reset values: pcpi_wr 0, pcpi_rd 0, pcpi_wait 0, pcpi_ready 0, op_a..op_d 0, op_input_STB 0, op_output_BUSY 1, last_latency 0, state IDLE.
- Reset takes effect asynchronously at any state, including mid-operation. Release is synchronous to clk.
- pcpi_wait rises 1 cycle after match is sampled. This is well inside the CPU's 16-cycle PCPI timeout.
- pcpi_ready and pcpi_wr rise 1 cycle after op_output_STB is sampled high, as a single-cycle pulse. pcpi_rd is valid in that cycle.
- A request still presented in the cycle after pcpi_ready is ignored, because RESPOND and DRAIN occupy at least 2 cycles.
- op_input_STB is held until op_BUSY is seen, so the minimum WAIT_ACCEPT is 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `pcpi_bf16_pkg`:
  - state enum (IDLE, WAIT_ACCEPT, WAIT_RESULT, RESPOND, DRAIN)
  - default OPCODE/FUNCT3/FUNCT7 constants
  - `insn_match` function
- No sub-module. Decode is the package function, and the counter is inline.

## Test plan
The bench uses a behavioural datapath model.
- Basic op: rs1=0x3F804000, rs2=0x40404080 → op_a/b/c/d = 3F80/4000/4040/4080. Model returns 0x4160 → pcpi_rd=0x00004160, pcpi_wr=pcpi_ready=1 for exactly 1 cycle, pcpi_wait low the same cycle.
- Non-matching insn (funct7=0) with pcpi_valid high for 20 cycles → pcpi_wait, pcpi_ready and op_input_STB stay 0.
- op_BUSY high for 5 cycles at request → no STB and no pcpi_wait until op_BUSY falls. Then normal completion with the same operands.
- Latency: model raises BUSY 1 cycle after sampling STB and asserts op_output_STB in the 8th WAIT_RESULT cycle → last_latency=10.
- Abort: drop pcpi_valid in WAIT_RESULT → result drained (op_output_STB falls, op_output_BUSY returns to 1), pcpi_ready never pulses, pcpi_rd unchanged.
- Async reset asserted mid-WAIT_RESULT → all outputs at reset values without a clock edge. After release, a new request completes normally.
